n2_dmem_arb: RTL and testbench
==============================

# n2_dmem_arb

Two-requester arbiter for the single data-memory port. Requester 0 is the core LSU (load/store queue output); requester 1 is a secondary master (debug/DMA/config engine). Arbitration is round-robin with request hold while the memory stalls grant. An in-order tag FIFO routes each memory response back to the requester that issued it. The arbiter adds zero cycles on the request and response paths.

## Interface
Parameters:
- `TAG_DEPTH`, default 8: maximum outstanding accepted-but-unanswered requests. Power of two, at least 2.

Ports (`mN_*` means one set each for N = 0 and N = 1):
- `clk`  in  1  clock
- `resetn`  in  1  reset, asynchronous, active-low
- `mN_req_i`  in  1  request valid; held until granted
- `mN_we_i`  in  1  1 = store, 0 = load
- `mN_addr_i`  in  32  byte address
- `mN_wdata_i`  in  32  store data, already lane-replicated
- `mN_wstrb_i`  in  4  byte strobes
- `mN_gnt_o`  out  1  request accepted this cycle
- `mN_ready_o`  out  1  response for this requester's oldest request
- `mN_rdata_o`  out  32  read data; `mem_rdata_i` broadcast to both requesters
- `mem_req_o`, `mem_we_o`, `mem_addr_o`, `mem_wdata_o`, `mem_wstrb_o`  out  1/1/32/32/4  memory request
- `mem_gnt_i`  in  1  memory accepts `mem_req_o` this cycle
- `mem_ready_i`  in  1  one response, in order (stores included)
- `mem_rdata_i`  in  32  read data
- `outstanding_o`  out  $clog2(TAG_DEPTH)+1  current tag FIFO occupancy
- `err_o`  out  1  sticky protocol error

## Operation
- **Transfer rule.** A request transfers when req and gnt are both high in the same cycle. Every transferred request yields exactly one `mem_ready_i`. Responses come back in issue order.
- **Owner selection.**
  - Only one requester active: that requester owns the port.
  - Both active: the requester other than `last_gnt` owns the port.
  - `last_gnt` resets to 1, so requester 0 wins the first tie.
- **Hold FSM, states IDLE and HOLD.**
  - IDLE → HOLD when `mem_req_o & ~mem_gnt_i`. The current owner is latched into `hold_id`.
  - In HOLD the owner is forced to `hold_id` regardless of the other requester. This keeps the memory-side address and data stable.
  - HOLD → IDLE on `mem_gnt_i`.
  - If the held requester drops req (illegal), set `err_o` and return to IDLE.
- **Request mux.**
  - `mem_req_o` = owner's req & ~`tag_full`.
  - `mem_we_o`, `mem_addr_o`, `mem_wdata_o`, `mem_wstrb_o` = owner's fields.
  - `mem_wstrb_o` is forced to 0 when `we` = 0.
- **Grant.** `mN_gnt_o` = `mem_gnt_i & mem_req_o & (owner == N)`. On grant, push N into the tag FIFO and set `last_gnt` to N.
- **Response.**
  - On `mem_ready_i`, pop the tag FIFO.
  - `mN_ready_o` = `mem_ready_i & (head == N) & ~tag_empty`.
- **Boundary conditions.**
  - Full: `mem_req_o` is deasserted and no grant is issued. Held state persists.
  - Simultaneous push and pop when full: the pop frees the slot for the next cycle only. No same-cycle pass-through.
  - Simultaneous push and pop otherwise: occupancy is unchanged.
  - Empty: `mem_ready_i` with an empty FIFO sets `err_o`, no `mN_ready_o` is driven, and pointers are unchanged.
  - Pointer wrap-around at `TAG_DEPTH`. The extra MSB in each pointer distinguishes full from empty.
- **Reset mid-operation.**
  - The FIFO is flushed, state returns to IDLE, `last_gnt` = 1 and `err_o` = 0.
  - In-flight memory responses arriving after reset hit the empty case and raise `err_o`. The memory must be reset together with this block.

## Timing
- Reset values:
  - all `*_gnt_o`, `*_ready_o`, `mem_req_o`, `mem_we_o` = 0
  - `mem_addr_o`, `mem_wdata_o`, `mem_wstrb_o` = 0 when no owner is active
  - `outstanding_o` = 0, `err_o` = 0
- Request path is combinational: `mN_req_i` → `mem_req_o`, and `mem_gnt_i` → `mN_gnt_o`, in the same cycle.
- Response path is combinational: `mem_ready_i` → `mN_ready_o`, zero added latency.
- Registered state:
  - tag FIFO pointers and storage
  - FSM state, `hold_id`, `last_gnt`, `err_o`
- `outstanding_o` updates on the cycle after a push or pop.
- Maximum throughput is one grant per cycle. Back-to-back grants alternate between requesters when both request continuously.

## Structure
- Shared package `NanoCore_pkg` gets:
  - `typedef logic arb_id_t`
  - `localparam DMEM_ARB_TAG_DEPTH = 8`
  - `typedef enum logic {ARB_IDLE, ARB_HOLD} arb_state_t`
- One sub-module, `n2_tag_fifo`: synchronous FIFO of `arb_id_t`, depth `TAG_DEPTH`, with push/pop/full/empty/count outputs and a combinational head. It sits alongside the arbiter logic inside `n2_dmem_arb`.

## Test plan
- **Single requester:** m0 load to `addr=0x100`, `mem_gnt_i=1`, then 2 cycles later `mem_ready_i=1` with `rdata=0xDEADBEEF` → `m0_gnt_o` in the same cycle, `m0_ready_o` pulse with `m0_rdata_o=0xDEADBEEF`, `m1_ready_o=0`.
- **Round-robin:** both requesters request continuously, `mem_gnt_i=1` → grants in order m0, m1, m0, m1. Responses returned in order → `ready` routes m0, m1, m0, m1.
- **Hold:** both request, `mem_gnt_i=0` for 3 cycles → `mem_addr_o` stays m0's address and m1 receives no grant. `mem_gnt_i=1` → m0 granted, m1 granted in the next cycle.
- **Full:** 8 grants with no ready → `outstanding_o=8`, `mem_req_o=0`. One `mem_ready_i` → `outstanding_o=7`, and a grant resumes in the following cycle.
- **Errors:** `mem_ready_i` with an empty FIFO → `err_o=1` and no ready output. Assert `resetn` low mid-traffic → `outstanding_o=0`, `err_o=0`, and the next tie goes to m0.
- **Store strobes:** m1 store with `wstrb=4'b0100`, `we=1` → `mem_wstrb_o=4'b0100`. A load with `wstrb=4'b1111` → `mem_wstrb_o=0`.

Source files
------------

// File: rtl/NanoCore_pkg.sv
// Shared NanoCore types: arbiter requester id, tag FIFO depth, hold FSM states.
package NanoCore_pkg;

  typedef logic arb_id_t;

  localparam int DMEM_ARB_TAG_DEPTH = 8;

  typedef enum logic {ARB_IDLE, ARB_HOLD} arb_state_t;

endpackage

// File: rtl/n2_tag_fifo.sv
// In-order FIFO of requester ids. Each entry is one accepted memory request
// that is still waiting for its response. The head is read combinationally so
// a response can be routed in the same cycle it arrives.
module n2_tag_fifo
  import NanoCore_pkg::*;
#(
  parameter int DEPTH = DMEM_ARB_TAG_DEPTH
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push_i,
  input  arb_id_t                  push_id_i,
  input  logic                     pop_i,
  output arb_id_t                  head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Pointers carry one extra MSB so that full and empty can be told apart.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  arb_id_t     mem_q [DEPTH];
  arb_id_t     mem_d [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  // A push into a full FIFO or a pop from an empty one is ignored.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Next pointers and storage contents.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_id_i;
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // Pointer and storage registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 1'b0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/n2_dmem_arb.sv
// Two-requester round-robin arbiter for the data-memory port.
// Request and response paths are combinational; a tag FIFO routes responses.
//
//   state    | meaning
//   ARB_IDLE | owner picked each cycle by round-robin
//   ARB_HOLD | memory stalled a request; owner pinned to hold_id until granted
module n2_dmem_arb
  import NanoCore_pkg::*;
#(
  parameter int TAG_DEPTH = DMEM_ARB_TAG_DEPTH
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         m0_req_i,
  input  logic                         m0_we_i,
  input  logic [31:0]                  m0_addr_i,
  input  logic [31:0]                  m0_wdata_i,
  input  logic [3:0]                   m0_wstrb_i,
  output logic                         m0_gnt_o,
  output logic                         m0_ready_o,
  output logic [31:0]                  m0_rdata_o,
  input  logic                         m1_req_i,
  input  logic                         m1_we_i,
  input  logic [31:0]                  m1_addr_i,
  input  logic [31:0]                  m1_wdata_i,
  input  logic [3:0]                   m1_wstrb_i,
  output logic                         m1_gnt_o,
  output logic                         m1_ready_o,
  output logic [31:0]                  m1_rdata_o,
  output logic                         mem_req_o,
  output logic                         mem_we_o,
  output logic [31:0]                  mem_addr_o,
  output logic [31:0]                  mem_wdata_o,
  output logic [3:0]                   mem_wstrb_o,
  input  logic                         mem_gnt_i,
  input  logic                         mem_ready_i,
  input  logic [31:0]                  mem_rdata_i,
  output logic [$clog2(TAG_DEPTH):0]   outstanding_o,
  output logic                         err_o
);

  arb_state_t state_q, state_d;
  arb_id_t    hold_id_q, hold_id_d;
  arb_id_t    last_gnt_q, last_gnt_d;
  logic       err_q, err_d;

  arb_id_t    owner;
  logic       owner_req;
  logic       push;
  logic       pop;
  logic       tag_full;
  logic       tag_empty;
  arb_id_t    tag_head;

  n2_tag_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push_i    (push),
    .push_id_i (owner),
    .pop_i     (pop),
    .head_o    (tag_head),
    .full_o    (tag_full),
    .empty_o   (tag_empty),
    .count_o   (outstanding_o)
  );

  // Owner: pinned while holding, otherwise round-robin on a tie.
  always_comb begin
    owner = 1'b0;
    if (state_q == ARB_HOLD) begin
      owner = hold_id_q;
    end else if (m0_req_i && m1_req_i) begin
      owner = ~last_gnt_q;
    end else if (m1_req_i) begin
      owner = 1'b1;
    end
  end

  // Memory-side request mux; fields are zero when the owner is not requesting.
  always_comb begin
    owner_req   = owner ? m1_req_i : m0_req_i;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wstrb_o = '0;
    if (owner_req) begin
      if (owner) begin
        mem_we_o    = m1_we_i;
        mem_addr_o  = m1_addr_i;
        mem_wdata_o = m1_wdata_i;
        mem_wstrb_o = m1_we_i ? m1_wstrb_i : 4'b0000;
      end else begin
        mem_we_o    = m0_we_i;
        mem_addr_o  = m0_addr_i;
        mem_wdata_o = m0_wdata_i;
        mem_wstrb_o = m0_we_i ? m0_wstrb_i : 4'b0000;
      end
    end
  end

  // No request leaves while every tag slot is taken, so a response that
  // frees a slot only enables the next grant one cycle later.
  assign mem_req_o  = owner_req & ~tag_full;
  assign push       = mem_req_o & mem_gnt_i;
  assign m0_gnt_o   = push & (owner == 1'b0);
  assign m1_gnt_o   = push & (owner == 1'b1);

  assign pop        = mem_ready_i & ~tag_empty;
  assign m0_ready_o = pop & (tag_head == 1'b0);
  assign m1_ready_o = pop & (tag_head == 1'b1);
  assign m0_rdata_o = mem_rdata_i;
  assign m1_rdata_o = mem_rdata_i;

  assign err_o      = err_q;

  // Hold FSM next state, round-robin history and sticky protocol error.
  always_comb begin
    state_d    = state_q;
    hold_id_d  = hold_id_q;
    last_gnt_d = push ? owner : last_gnt_q;
    err_d      = err_q | (mem_ready_i & tag_empty);
    case (state_q)
      ARB_IDLE: begin
        if (mem_req_o && !mem_gnt_i) begin
          state_d   = ARB_HOLD;
          hold_id_d = owner;
        end
      end
      ARB_HOLD: begin
        // Leaving only on an actual transfer keeps the hold across a full FIFO.
        if (!owner_req) begin
          err_d   = 1'b1;
          state_d = ARB_IDLE;
        end else if (push) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ARB_IDLE;
      hold_id_q  <= 1'b0;
      last_gnt_q <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_id_q  <= hold_id_d;
      last_gnt_q <= last_gnt_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_n2_dmem_arb.sv
// Directed bench for n2_dmem_arb: a vector table plus hand-written sequences.
module tb_n2_dmem_arb;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        m0_req = 0, m0_we = 0;
  logic [31:0] m0_addr = 32'h100, m0_wdata = 32'h1111_0000;
  logic [3:0]  m0_wstrb = 4'hF;
  logic        m1_req = 0, m1_we = 0;
  logic [31:0] m1_addr = 32'h200, m1_wdata = 32'h2222_0000;
  logic [3:0]  m1_wstrb = 4'hF;
  logic        mem_gnt = 0, mem_ready = 0;
  logic [31:0] mem_rdata = 0;

  logic        m0_gnt_o, m0_ready_o, m1_gnt_o, m1_ready_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic [3:0]  outstanding_o;
  logic        err_o;

  int n_cmp = 0;
  int n_fail = 0;

  n2_dmem_arb #(.TAG_DEPTH(8)) dut (
    .clk(clk), .resetn(resetn),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr),
    .m0_wdata_i(m0_wdata), .m0_wstrb_i(m0_wstrb),
    .m0_gnt_o(m0_gnt_o), .m0_ready_o(m0_ready_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr),
    .m1_wdata_i(m1_wdata), .m1_wstrb_i(m1_wstrb),
    .m1_gnt_o(m1_gnt_o), .m1_ready_o(m1_ready_o), .m1_rdata_o(m1_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
    .mem_gnt_i(mem_gnt), .mem_ready_i(mem_ready), .mem_rdata_i(mem_rdata),
    .outstanding_o(outstanding_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r0, r1, gnt, rdy;
    logic        g0, g1, q0, q1, mreq;
    logic [31:0] addr;
    logic [3:0]  outs;
    logic        err;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(input logic r0, r1, gnt, rdy, g0, g1, q0, q1, mreq,
                              input logic [31:0] addr, input logic [3:0] outs,
                              input logic err);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.gnt = gnt; v.rdy = rdy;
    v.g0 = g0; v.g1 = g1; v.q0 = q0; v.q1 = q1; v.mreq = mreq;
    v.addr = addr; v.outs = outs; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r0, r1, gnt, rdy);
    m0_req = r0; m1_req = r1; mem_gnt = gnt; mem_ready = rdy;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(0, 0, 0, 0);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    //                 r0 r1 gt rd  g0 g1 q0 q1 mrq addr      out err
    vecs[0]  = mk(0, 0, 0, 0,  0, 0, 0, 0, 0,  32'h0,   4'd0, 0);
    vecs[1]  = mk(1, 0, 1, 0,  1, 0, 0, 0, 1,  32'h100, 4'd0, 0);
    vecs[2]  = mk(0, 0, 0, 0,  0, 0, 0, 0, 0,  32'h0,   4'd1, 0);
    vecs[3]  = mk(0, 0, 0, 1,  0, 0, 1, 0, 0,  32'h0,   4'd1, 0);
    vecs[4]  = mk(1, 1, 1, 0,  0, 1, 0, 0, 1,  32'h200, 4'd0, 0);
    vecs[5]  = mk(1, 1, 1, 0,  1, 0, 0, 0, 1,  32'h100, 4'd1, 0);
    vecs[6]  = mk(1, 1, 1, 0,  0, 1, 0, 0, 1,  32'h200, 4'd2, 0);
    vecs[7]  = mk(1, 1, 1, 0,  1, 0, 0, 0, 1,  32'h100, 4'd3, 0);
    vecs[8]  = mk(0, 0, 0, 1,  0, 0, 0, 1, 0,  32'h0,   4'd4, 0);
    vecs[9]  = mk(0, 0, 0, 1,  0, 0, 1, 0, 0,  32'h0,   4'd3, 0);
    vecs[10] = mk(0, 0, 0, 1,  0, 0, 0, 1, 0,  32'h0,   4'd2, 0);
    vecs[11] = mk(0, 0, 0, 1,  0, 0, 1, 0, 0,  32'h0,   4'd1, 0);
    vecs[12] = mk(0, 0, 0, 0,  0, 0, 0, 0, 0,  32'h0,   4'd0, 0);
    vecs[13] = mk(0, 0, 0, 1,  0, 0, 0, 0, 0,  32'h0,   4'd0, 0);
    vecs[14] = mk(0, 0, 0, 0,  0, 0, 0, 0, 0,  32'h0,   4'd0, 1);

    #1;
    chk("rst_outstanding", 32'(outstanding_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_mem_req", 32'(mem_req_o), 32'd0);
    do_reset();

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(vecs[i].r0, vecs[i].r1, vecs[i].gnt, vecs[i].rdy);
      mem_rdata = (i == 3) ? 32'hDEAD_BEEF : 32'hC0DE_0000 + 32'(i);
      #1;
      chk($sformatf("v%0d_m0_gnt", i), 32'(m0_gnt_o), 32'(vecs[i].g0));
      chk($sformatf("v%0d_m1_gnt", i), 32'(m1_gnt_o), 32'(vecs[i].g1));
      chk($sformatf("v%0d_m0_ready", i), 32'(m0_ready_o), 32'(vecs[i].q0));
      chk($sformatf("v%0d_m1_ready", i), 32'(m1_ready_o), 32'(vecs[i].q1));
      chk($sformatf("v%0d_mem_req", i), 32'(mem_req_o), 32'(vecs[i].mreq));
      chk($sformatf("v%0d_mem_addr", i), mem_addr_o, vecs[i].addr);
      chk($sformatf("v%0d_outstanding", i), 32'(outstanding_o), 32'(vecs[i].outs));
      chk($sformatf("v%0d_err", i), 32'(err_o), 32'(vecs[i].err));
      if (vecs[i].q0) chk($sformatf("v%0d_m0_rdata", i), m0_rdata_o,
                          (i == 3) ? 32'hDEAD_BEEF : 32'hC0DE_0000 + 32'(i));
    end

    // Reset in the middle of traffic, after the last grant went to m0.
    @(negedge clk); drive(1, 0, 1, 0); #1 chk("mid_g0a", 32'(m0_gnt_o), 32'd1);
    @(negedge clk); drive(1, 0, 1, 0); #1 chk("mid_g0b", 32'(m0_gnt_o), 32'd1);
    @(negedge clk); drive(0, 0, 0, 0); #1 chk("mid_out2", 32'(outstanding_o), 32'd2);
    resetn = 1'b0; #1;
    chk("mid_rst_out", 32'(outstanding_o), 32'd0);
    chk("mid_rst_err", 32'(err_o), 32'd0);
    @(negedge clk); resetn = 1'b1; drive(1, 1, 1, 0); #1;
    chk("mid_tie_g0", 32'(m0_gnt_o), 32'd1);
    chk("mid_tie_g1", 32'(m1_gnt_o), 32'd0);

    // Hold: a stalled m0 request keeps the port even when the tie favours m1.
    do_reset();
    @(negedge clk); drive(1, 0, 1, 0); #1 chk("hold_a_g0", 32'(m0_gnt_o), 32'd1);
    @(negedge clk); drive(1, 0, 0, 0); #1 chk("hold_b_addr", mem_addr_o, 32'h100);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); drive(1, 1, 0, 0); #1;
      chk("hold_addr", mem_addr_o, 32'h100);
      chk("hold_mreq", 32'(mem_req_o), 32'd1);
      chk("hold_no_g1", 32'(m1_gnt_o), 32'd0);
    end
    @(negedge clk); drive(1, 1, 1, 0); #1;
    chk("hold_rel_g0", 32'(m0_gnt_o), 32'd1);
    chk("hold_rel_g1", 32'(m1_gnt_o), 32'd0);
    @(negedge clk); drive(1, 1, 1, 0); #1;
    chk("hold_next_g1", 32'(m1_gnt_o), 32'd1);
    chk("hold_next_addr", mem_addr_o, 32'h200);
    chk("hold_next_out", 32'(outstanding_o), 32'd2);
    // Held requester withdrawing its request is a protocol error.
    @(negedge clk); drive(0, 1, 0, 0); #1 chk("drop_mreq", 32'(mem_req_o), 32'd1);
    @(negedge clk); drive(0, 0, 0, 0); #1 chk("drop_err_pre", 32'(err_o), 32'd0);
    @(negedge clk); #1 chk("drop_err", 32'(err_o), 32'd1);

    // Full FIFO, one response, then drain through the pointer wrap.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); drive(1, 0, 1, 0); #1;
      chk("full_fill_g0", 32'(m0_gnt_o), 32'd1);
      chk("full_fill_out", 32'(outstanding_o), 32'(c));
    end
    @(negedge clk); drive(1, 0, 1, 1); mem_rdata = 32'hDEAD_BEEF; #1;
    chk("full_out8", 32'(outstanding_o), 32'd8);
    chk("full_mreq", 32'(mem_req_o), 32'd0);
    chk("full_no_g0", 32'(m0_gnt_o), 32'd0);
    chk("full_ready0", 32'(m0_ready_o), 32'd1);
    chk("full_rdata", m0_rdata_o, 32'hDEAD_BEEF);
    @(negedge clk); drive(1, 0, 1, 0); #1;
    chk("full_out7", 32'(outstanding_o), 32'd7);
    chk("full_resume_g0", 32'(m0_gnt_o), 32'd1);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); drive(0, 0, 0, 1); #1;
      chk("drain_out", 32'(outstanding_o), 32'(8 - c));
      chk("drain_ready0", 32'(m0_ready_o), 32'd1);
    end
    @(negedge clk); drive(0, 0, 0, 0); #1;
    chk("drain_empty", 32'(outstanding_o), 32'd0);
    chk("drain_err", 32'(err_o), 32'd0);

    // Store strobes pass through, load strobes are masked.
    do_reset();
    @(negedge clk);
    m1_we = 1; m1_wstrb = 4'b0100; m1_wdata = 32'h00AB_0000; drive(0, 1, 1, 0); #1;
    chk("st_wstrb", 32'(mem_wstrb_o), 32'h4);
    chk("st_we", 32'(mem_we_o), 32'd1);
    chk("st_wdata", mem_wdata_o, 32'h00AB_0000);
    chk("st_g1", 32'(m1_gnt_o), 32'd1);
    @(negedge clk);
    m1_we = 0; m0_we = 0; m0_wstrb = 4'hF; drive(1, 0, 1, 0); #1;
    chk("ld_wstrb", 32'(mem_wstrb_o), 32'h0);
    chk("ld_we", 32'(mem_we_o), 32'd0);
    chk("ld_g0", 32'(m0_gnt_o), 32'd1);
    @(negedge clk); drive(0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
